// File: rtl/mcs4_pkg.sv
// Shared MCS-4 timing encodings: subcycle and slot numbering used by every board,
// plus the sequencer state type and counter widths sized for the parameter maxima.
package mcs4_pkg;

  typedef enum logic [2:0] {
    SC_A1 = 3'd0,
    SC_A2 = 3'd1,
    SC_A3 = 3'd2,
    SC_M1 = 3'd3,
    SC_M2 = 3'd4,
    SC_X1 = 3'd5,
    SC_X2 = 3'd6,
    SC_X3 = 3'd7
  } subcycle_e;

  typedef enum logic [1:0] {
    SLOT_S0 = 2'd0,
    SLOT_S1 = 2'd1,
    SLOT_S2 = 2'd2,
    SLOT_S3 = 2'd3
  } slot_e;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } seq_state_e;

  // Divider and power-on-clear counters both have to reach 254.
  localparam int DIV_W = 8;
  localparam int POC_W = 8;

  function automatic logic [7:0] subcycle_onehot(input subcycle_e sc);
    return 8'd1 << sc;
  endfunction

endpackage

// File: rtl/timing_gen_phase_gen.sv
// Slot/divider engine: divides sysclk into four CLK_DIV-long slots per subcycle,
// drives the registered two-phase clocks and flags the last sysclk of a subcycle.
module phase_gen
  import mcs4_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       sysclk,
  input  logic       poc_n,
  input  logic       run,
  input  logic       show,
  output logic       clk1,
  output logic       clk2,
  output logic       sc_end,
  output logic [1:0] slot,
  output logic [1:0] slot_nxt
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_nxt;
  slot_e            slot_q;
  slot_e            slot_n;
  logic             div_wrap;

  always_comb begin
    div_wrap = (div_q == DIV_W'(CLK_DIV - 1));
    div_nxt  = div_q;
    slot_n   = slot_q;
    if (run) begin
      if (div_wrap) begin
        div_nxt = '0;
        slot_n  = slot_e'(slot_q + 2'd1);
      end else begin
        div_nxt = div_q + DIV_W'(1);
      end
    end
  end

  assign sc_end   = run && div_wrap && (slot_q == SLOT_S3);
  assign slot     = slot_q;
  assign slot_nxt = slot_n;

  // Clocks are decoded from the slot being entered, so they line up with the counters.
  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      div_q  <= '0;
      slot_q <= SLOT_S0;
      clk1   <= 1'b0;
      clk2   <= 1'b0;
    end else begin
      div_q  <= div_nxt;
      slot_q <= slot_n;
      clk1   <= show && (slot_n == SLOT_S0);
      clk2   <= show && (slot_n == SLOT_S2);
    end
  end

endmodule

// File: rtl/timing_gen.sv
// MCS-4 timing generator: two-phase clocks, one-hot subcycle strobes, sync,
// power-on clear and halt/single-step control of the instruction-cycle sequencer.
module timing_gen
  import mcs4_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int POC_CYCLES = 8
) (
  input  logic       sysclk,
  input  logic       poc_n,
  input  logic       halt,
  input  logic       step,
  output logic       halted,
  output logic       clk1,
  output logic       clk2,
  output logic       a12,
  output logic       a22,
  output logic       a32,
  output logic       m12,
  output logic       m22,
  output logic       x12,
  output logic       x22,
  output logic       x32,
  output logic       sync,
  output logic       poc,
  output logic       m12_m22_clk1_m11_m12,
  output logic [5:0] dbg_state
);

  logic [1:0]       rel_sync;
  logic             released;
  logic             active_q;
  logic             active_nxt;
  seq_state_e       st_q;
  seq_state_e       st_nxt;
  subcycle_e        sc_q;
  subcycle_e        sc_nxt;
  logic             sc_end;
  logic             cyc_end;
  logic [1:0]       slot;
  logic [1:0]       slot_nxt;
  logic [POC_W-1:0] poc_cnt;
  logic [7:0]       strobe_q;
  logic [7:0]       strobe_nxt;
  logic             mlatch_nxt;

  phase_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_phase (
    .sysclk   (sysclk),
    .poc_n    (poc_n),
    .run      (active_q),
    .show     (active_nxt),
    .clk1     (clk1),
    .clk2     (clk2),
    .sc_end   (sc_end),
    .slot     (slot),
    .slot_nxt (slot_nxt)
  );

  // Reset release is brought into the sysclk domain before the sequencer may start.
  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      rel_sync <= 2'b00;
    end else begin
      rel_sync <= {rel_sync[0], 1'b1};
    end
  end

  assign released = rel_sync[1];
  assign cyc_end  = sc_end && (sc_q == SC_X3);

  always_comb begin
    st_nxt     = st_q;
    active_nxt = 1'b0;
    sc_nxt     = sc_q;
    if (sc_end) begin
      sc_nxt = subcycle_e'(sc_q + 3'd1);
    end
    case (st_q)
      ST_RUN: begin
        active_nxt = released;
        // halt only counts at the instruction-cycle boundary and never during poc.
        if (cyc_end && halt && !poc_q_live()) begin
          st_nxt     = ST_HALTED;
          active_nxt = 1'b0;
        end
      end
      ST_HALTED: begin
        if (step || !halt) begin
          st_nxt     = ST_RUN;
          active_nxt = 1'b1;
        end
      end
      default: begin
        st_nxt     = ST_RUN;
        active_nxt = 1'b0;
      end
    endcase
    strobe_nxt = active_nxt ? subcycle_onehot(sc_nxt) : 8'd0;
    mlatch_nxt = active_nxt && ((sc_nxt == SC_M1) || (sc_nxt == SC_M2) ||
                                (slot_nxt == SLOT_S0));
  end

  function automatic logic poc_q_live();
    return poc;
  endfunction

  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      st_q                 <= ST_RUN;
      active_q             <= 1'b0;
      sc_q                 <= SC_A1;
      strobe_q             <= 8'd0;
      sync                 <= 1'b0;
      halted               <= 1'b0;
      m12_m22_clk1_m11_m12 <= 1'b0;
    end else begin
      st_q                 <= st_nxt;
      active_q             <= active_nxt;
      sc_q                 <= sc_nxt;
      strobe_q             <= strobe_nxt;
      sync                 <= active_nxt && (sc_nxt == SC_X3);
      halted               <= (st_nxt == ST_HALTED);
      m12_m22_clk1_m11_m12 <= mlatch_nxt;
    end
  end

  // poc drops at the end of the POC_CYCLES-th complete instruction cycle.
  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      poc     <= 1'b1;
      poc_cnt <= '0;
    end else if (poc && cyc_end) begin
      if (poc_cnt == POC_W'(POC_CYCLES - 1)) begin
        poc <= 1'b0;
      end else begin
        poc_cnt <= poc_cnt + POC_W'(1);
      end
    end
  end

  assign a12 = strobe_q[SC_A1];
  assign a22 = strobe_q[SC_A2];
  assign a32 = strobe_q[SC_A3];
  assign m12 = strobe_q[SC_M1];
  assign m22 = strobe_q[SC_M2];
  assign x12 = strobe_q[SC_X1];
  assign x22 = strobe_q[SC_X2];
  assign x32 = strobe_q[SC_X3];

  // Debug view: {sequencer state, subcycle, slot}.
  assign dbg_state = {st_q, sc_q, slot};

endmodule

// File: tb/tb_timing_gen.sv
// Bench for timing_gen: a position-in-cycle reference model drives an expected queue
// for two instances (CLK_DIV=4/POC_CYCLES=8 and CLK_DIV=1/POC_CYCLES=2).
module tb_timing_gen;

  localparam int M_WAIT = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  logic poc_n0 = 1'b0, halt0 = 1'b0, step0 = 1'b0;
  logic poc_n1 = 1'b0, halt1 = 1'b0, step1 = 1'b0;
  logic halted0, clk1_0, clk2_0, a12_0, a22_0, a32_0, m12_0, m22_0, x12_0, x22_0, x32_0;
  logic sync0, poc0, ml0;
  logic halted1, clk1_1, clk2_1, a12_1, a22_1, a32_1, m12_1, m22_1, x12_1, x22_1, x32_1;
  logic sync1, poc1, ml1;
  logic [5:0] dbg0, dbg1;
  logic [13:0] obs0, obs1;

  timing_gen #(.CLK_DIV(4), .POC_CYCLES(8)) u0 (
    .sysclk(sysclk), .poc_n(poc_n0), .halt(halt0), .step(step0), .halted(halted0),
    .clk1(clk1_0), .clk2(clk2_0), .a12(a12_0), .a22(a22_0), .a32(a32_0), .m12(m12_0),
    .m22(m22_0), .x12(x12_0), .x22(x22_0), .x32(x32_0), .sync(sync0), .poc(poc0),
    .m12_m22_clk1_m11_m12(ml0), .dbg_state(dbg0)
  );

  timing_gen #(.CLK_DIV(1), .POC_CYCLES(2)) u1 (
    .sysclk(sysclk), .poc_n(poc_n1), .halt(halt1), .step(step1), .halted(halted1),
    .clk1(clk1_1), .clk2(clk2_1), .a12(a12_1), .a22(a22_1), .a32(a32_1), .m12(m12_1),
    .m22(m22_1), .x12(x12_1), .x22(x22_1), .x32(x32_1), .sync(sync1), .poc(poc1),
    .m12_m22_clk1_m11_m12(ml1), .dbg_state(dbg1)
  );

  assign obs0 = {halted0, poc0, sync0, ml0, clk1_0, clk2_0,
                 x32_0, x22_0, x12_0, m22_0, m12_0, a32_0, a22_0, a12_0};
  assign obs1 = {halted1, poc1, sync1, ml1, clk1_1, clk2_1,
                 x32_1, x22_1, x12_1, m22_1, m12_1, a32_1, a22_1, a12_1};

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge sysclk);
    #1;
  endtask

  // Reference model: where in the 32*CLK_DIV-long instruction cycle each instance is.
  int m_div  [2] = '{4, 1};
  int m_pocn [2] = '{8, 2};
  int m_mode [2] = '{M_WAIT, M_WAIT};
  int m_rel  [2] = '{0, 0};
  int m_pos  [2] = '{0, 0};
  int m_done [2] = '{0, 0};
  bit m_poc  [2] = '{1'b1, 1'b1};

  task automatic model_step(input int k, input logic pn, input logic h, input logic s);
    int last;
    bit stop;
    last = 32 * m_div[k] - 1;
    if (!pn) begin
      m_mode[k] = M_WAIT;
      m_rel[k]  = 0;
      m_pos[k]  = 0;
      m_done[k] = 0;
      m_poc[k]  = 1'b1;
    end else begin
      case (m_mode[k])
        M_WAIT: begin
          if (m_rel[k] < 2) m_rel[k]++;
          else begin
            m_mode[k] = M_RUN;
            m_pos[k]  = 0;
          end
        end
        M_RUN: begin
          if (m_pos[k] == last) begin
            stop = h && !m_poc[k];
            if (m_poc[k]) begin
              m_done[k]++;
              if (m_done[k] == m_pocn[k]) m_poc[k] = 1'b0;
            end
            m_pos[k] = 0;
            if (stop) m_mode[k] = M_HALT;
          end else begin
            m_pos[k]++;
          end
        end
        default: begin
          if (s || !h) begin
            m_mode[k] = M_RUN;
            m_pos[k]  = 0;
          end
        end
      endcase
    end
  endtask

  function automatic logic [13:0] model_outs(input int k);
    int d, sub, slot;
    logic [13:0] v;
    d    = m_div[k];
    sub  = m_pos[k] / (4 * d);
    slot = (m_pos[k] / d) % 4;
    v    = '0;
    v[13] = (m_mode[k] == M_HALT);
    v[12] = m_poc[k];
    if (m_mode[k] == M_RUN) begin
      v[11]  = (sub == 7);
      v[9]   = (slot == 0);
      v[8]   = (slot == 2);
      v[10]  = (slot == 0) || (sub == 3) || (sub == 4);
      v[sub] = 1'b1;
    end
    return v;
  endfunction

  logic [13:0] exp_q0[$];
  logic [13:0] exp_q1[$];

  always @(posedge sysclk) begin
    cyc++;
    model_step(0, poc_n0, halt0, step0);
    model_step(1, poc_n1, halt1, step1);
    exp_q0.push_back(model_outs(0));
    exp_q1.push_back(model_outs(1));
  end

  always @(negedge sysclk) begin
    if (exp_q0.size() > 0) check("u0_outs", 32'(obs0), 32'(exp_q0.pop_front()));
    if (exp_q1.size() > 0) check("u1_outs", 32'(obs1), 32'(exp_q1.pop_front()));
  end

  // Second instance: free-running random halt/step with CLK_DIV=1.
  bit done = 1'b0;
  int overlap1 = 0, ml_bad1 = 0, clk1_seen1 = 0;

  initial begin
    int hold;
    hold = 0;
    tick(); tick(); tick();
    poc_n1 = 1'b1;
    while (!done) begin
      if (hold == 0) begin
        halt1 = 1'($urandom_range(0, 1));
        hold  = $urandom_range(20, 200);
      end else begin
        hold--;
      end
      step1 = ($urandom_range(0, 31) == 0);
      tick();
      if (clk1_1 && clk2_1) overlap1++;
      if (ml1 != (m12_1 | m22_1 | clk1_1)) ml_bad1++;
      if (clk1_1) clk1_seen1++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no end of test, expected finish before 1 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, t_first, last_rise, a12_rises, sync_hi, bad_per, cnt, hold;
    bit prev_a12, prev_clk1, saw_x3;

    tick(); tick();
    check("rst_outs_u0", 32'(obs0), 32'h1000);
    check("rst_outs_u1", 32'(obs1), 32'h1000);
    check("rst_dbg_u0", 32'(dbg0), 32'h0);
    check("rst_dbg_u1", 32'(dbg1), 32'h0);
    tick();
    poc_n0 = 1'b1;

    n = 0;
    while (!clk1_0 && n < 10) begin tick(); n++; end
    check("first_clk1_within3", 32'(clk1_0 && (n <= 3)), 32'h1);

    // Power-on clear phase: random halt must be ignored.
    t_first = cyc; last_rise = cyc; prev_a12 = 1'b0; prev_clk1 = 1'b1;
    a12_rises = 0; sync_hi = 0; bad_per = 0; n = 0;
    while (poc0 && n < 1200) begin
      if (a12_0 && !prev_a12) a12_rises++;
      if (sync0) sync_hi++;
      prev_a12 = a12_0;
      halt0 = 1'($urandom_range(0, 1));
      tick();
      n++;
      if (clk1_0 && !prev_clk1) begin
        if (cyc - last_rise != 16) bad_per++;
        last_rise = cyc;
      end
      prev_clk1 = clk1_0;
    end
    halt0 = 1'b0;
    check("poc_len", 32'(cyc - t_first), 32'd1024);
    check("poc_fall_at_a1", 32'({clk1_0, a12_0}), 32'h3);
    check("a12_cnt_poc", 32'(a12_rises), 32'd8);
    check("sync_cnt_poc", 32'(sync_hi), 32'd128);
    check("clk1_period_bad", 32'(bad_per), 32'd0);

    // Halt raised in M2 and held: the cycle finishes through X3 first.
    n = 0;
    while (!m22_0 && n < 200) begin tick(); n++; end
    check("reach_m2", 32'(m22_0), 32'h1);
    halt0 = 1'b1;
    n = 0; saw_x3 = 1'b0;
    while (!halted0 && n < 300) begin
      tick();
      n++;
      if (x32_0) saw_x3 = 1'b1;
    end
    check("halt_latency", 32'(n), 32'd64);
    check("x3_before_halt", 32'(saw_x3), 32'h1);
    check("halted_outs", 32'(obs0), 32'h2000);

    // Single step with a second, ignored step mid-cycle.
    repeat (5) tick();
    step0 = 1'b1;
    tick();
    step0 = 1'b0;
    check("step_starts_a1", 32'({a12_0, clk1_0, halted0}), 32'h6);
    cnt = 1;
    while (cnt < 300) begin
      step0 = (cnt == 40);
      tick();
      if (halted0) break;
      cnt++;
    end
    step0 = 1'b0;
    check("step_len", 32'(cnt), 32'd128);

    halt0 = 1'b0;
    tick();
    check("resume_a1", 32'({a12_0, clk1_0, halted0}), 32'h6);

    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        halt0 = 1'($urandom_range(0, 1));
        hold  = $urandom_range(50, 400);
      end else begin
        hold--;
      end
      step0 = ($urandom_range(0, 63) == 0);
      tick();
    end

    // Reset in X1 S2 aborts at once, then the sequence restarts at A1.
    halt0 = 1'b0; step0 = 1'b0;
    n = 0;
    while (!(x12_0 && clk2_0) && n < 400) begin tick(); n++; end
    check("reach_x1_s2", 32'(x12_0 && clk2_0), 32'h1);
    poc_n0 = 1'b0;
    #1;
    check("abort_outs", 32'(obs0), 32'h1000);
    tick(); tick();
    poc_n0 = 1'b1;
    n = 0;
    while (!clk1_0 && n < 10) begin tick(); n++; end
    check("restart_a1", 32'({clk1_0, a12_0, n <= 3}), 32'h7);
    repeat (300) tick();

    done = 1'b1;
    tick(); tick();
    check("u1_overlap", 32'(overlap1), 32'd0);
    check("u1_mlatch_rule", 32'(ml_bad1), 32'd0);
    check("u1_clk1_activity", 32'(clk1_seen1 > 100), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/timing_gen.md
TIMING_GEN -- requirements
Module: timing_gen

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, sysclk cycles per phase slot (legal 1..255).
REQ-002 SHALL have parameter POC_CYCLES, default 8, instruction cycles poc is held after reset release (legal 1..255).
REQ-003 SHALL have port sysclk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port poc_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port halt  input  1  request to stop at the next instruction-cycle boundary.
REQ-006 SHALL have port step  input  1  one-sysclk pulse; while halted, runs exactly one instruction cycle.
REQ-007 SHALL have port halted  output  1  sequencer is stopped at the boundary.
REQ-008 SHALL have ports clk1, clk2  output  1 each  non-overlapping two-phase clocks.
REQ-009 SHALL have ports a12, a22, a32, m12, m22, x12, x22, x32  output  1 each  one-hot subcycle strobes.
REQ-010 SHALL have port sync  output  1  instruction-cycle marker.
REQ-011 SHALL have port poc  output  1  power-on clear, active-high, to datapath boards.
REQ-012 SHALL have port m12_m22_clk1_m11_m12  output  1  data-in latch enable.

Function
REQ-013 Each subcycle SHALL be four slots of CLK_DIV sysclk cycles: S0 clk1=1, S1 both 0, S2 clk2=1, S3 both 0.
REQ-014 Subcycle order SHALL be A1,A2,A3,M1,M2,X1,X2,X3, then wrap to A1; 8 subcycles = one instruction cycle = 32*CLK_DIV sysclk cycles.
REQ-015 Exactly one subcycle strobe SHALL be high through all four slots of its subcycle; none while halted or in reset.
REQ-016 sync SHALL be high for all four slots of X3.
REQ-017 clk1 and clk2 SHALL never be high in the same sysclk cycle; all outputs SHALL be registered (glitch-free).
REQ-018 m12_m22_clk1_m11_m12 SHALL equal m12 | m22 | clk1 (M11 is the same interval as M12 here), registered alongside them.
REQ-019 halt SHALL be sampled only at the end of X3 S3; if high, the sequencer enters HALTED instead of A1.
REQ-020 In HALTED all clocks and strobes SHALL be 0 and halted=1; halt high arriving mid-cycle SHALL NOT truncate the current instruction cycle.
REQ-021 step while HALTED SHALL start A1 S0 on the next sysclk; that cycle runs fully and re-checks halt at X3 end.
REQ-022 step while running, or during reset/poc, SHALL be ignored; step not queued.
REQ-023 HALTED with halt low SHALL resume at A1 S0 on the next sysclk.
REQ-024 Slot counter SHALL count 0..CLK_DIV-1 and wrap; slot and subcycle counters SHALL be sized for parameter maxima with no overflow.
REQ-025 State machine SHALL have states RUN and HALTED; RUN holds subcycle (3 bits), slot (2 bits), divider count.

Reset
REQ-026 poc_n low SHALL asynchronously force: clk1=clk2=0, all strobes=0, sync=0, halted=0, poc=1, subcycle=A1, slot=S0, divider=0.
REQ-027 Reset release SHALL be synchronized (2 flops) before sequencing begins; first clk1 SHALL appear within 3 sysclk cycles of release.
REQ-028 After release poc SHALL stay 1 for exactly POC_CYCLES complete instruction cycles, falling at end of the final X3 S3; sequencer runs normally (refresh) meanwhile.
REQ-029 halt SHALL be ignored while poc=1; reset asserted mid-cycle SHALL abort immediately.

Structure
REQ-030 Subcycle encoding (A1..X3 = 0..7) and slot encoding SHALL live in shared package mcs4_pkg for use by other boards.
REQ-031 Slot/divider logic SHALL be a sub-module named phase_gen producing clk1, clk2 and a subcycle-advance pulse; timing_gen holds subcycle, halt and poc logic.

Verification
REQ-032 CLK_DIV=4, no halt: clk1 rises every 16 sysclk, sync high 16 cycles out of 128, strobes one-hot in order A1..X3.
REQ-033 Release poc_n with POC_CYCLES=8: poc falls exactly 8*128 sysclk after first clk1; a12 seen 8 times while poc=1.
REQ-034 Pulse halt during M2: cycle completes through X3, then halted=1 and all outputs 0; no truncation.
REQ-035 While halted, pulse step once: exactly one A1..X3 sequence (128 sysclk) then halted again; second step mid-cycle ignored.
REQ-036 Assert poc_n low during X1 S2: clk2 and x12 drop same cycle, poc=1; after release sequence restarts at A1.
REQ-037 CLK_DIV=1: clk1/clk2 never overlap, m12_m22_clk1_m11_m12 high on every clk1 slot and all of M1, M2.
